// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 frame receiver: FSM states, frame bit
// counts and the odd-parity rule used to accept a received byte.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_e;

    localparam int DATA_BITS  = 8;
    localparam int FRAME_BITS = 11;
    localparam int BIT_CNT_W  = $clog2(DATA_BITS);

    // True when the data byte together with its parity bit holds an odd
    // number of ones, i.e. the frame passes the PS/2 odd-parity check.
    function automatic logic odd_parity_ok(input logic [DATA_BITS-1:0] byte_in,
                                           input logic                 parity_bit);
        return ^{byte_in, parity_bit};
    endfunction

endpackage

// File: rtl/ps2_byte_fifo.sv
// Show-ahead byte FIFO for received PS/2 bytes. Pointers carry one extra
// wrap bit so that full and empty are distinguishable. The head is kept in
// a register so it holds its last value once the FIFO drains.
module ps2_byte_fifo
    import ps2_pkg::*;
#(
    parameter int WIDTH = DATA_BITS,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             full
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   rd_next;
    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign rd_data = head_q;

    // Pointer updates and next head value; a pop frees a slot for a push in the same cycle.
    always_comb begin
        do_pop   = rd_en && !empty;
        do_push  = wr_en && (!full || do_pop);
        rd_next  = rd_ptr_q + 1'b1;
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop ? rd_next : rd_ptr_q;
        head_d   = head_q;
        if (empty) begin
            if (do_push) begin
                head_d = wr_data;
            end
        end else if (do_pop) begin
            if (rd_next == wr_ptr_q) begin
                if (do_push) begin
                    head_d = wr_data;
                end
            end else begin
                head_d = mem_q[rd_next[PTR_W-1:0]];
            end
        end
    end

    // Storage array; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= wr_data;
        end
    end

    // Pointer and head registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            head_q   <= head_d;
        end
    end

endmodule

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver. Samples the synchronised PS/2 clock on
// a divided tick, decodes start/8 data/parity/stop frames and buffers good
// bytes in a show-ahead FIFO. Errors are reported as one-cycle pulses.
// Optional build macro PS2_RX_GLITCH_FILTER_EN inserts a FILTER_LEN-tick
// stability filter on the PS/2 clock line ahead of edge detection.
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int CLK_DIV       = 100,
    parameter int TIMEOUT_TICKS = 200,
    parameter int FIFO_DEPTH    = 8,
    parameter int FILTER_LEN    = 4
) (
    input  logic                 qzt_clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 PS2C,
    input  logic                 PS2D,
    input  logic                 rd_en,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    output logic                 full,
    output logic                 err_parity,
    output logic                 err_frame,
    output logic                 err_overrun,
    output logic                 err_timeout
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int TO_W  = $clog2(TIMEOUT_TICKS + 1);

    logic                 ps2c_meta_q, ps2c_sync_q;
    logic                 ps2d_meta_q, ps2d_sync_q;
    logic [DIV_W-1:0]     div_q, div_d;
    logic                 tick;
    logic                 ps2c_level;
    logic                 prev_level_q, prev_level_d;
    logic                 fall_edge;

    ps2_state_e           state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic                 par_q, par_d;
    logic [TO_W-1:0]      to_cnt_q, to_cnt_d;
    logic                 push_req;
    logic                 err_parity_q, err_parity_d;
    logic                 err_frame_q, err_frame_d;
    logic                 err_overrun_q, err_overrun_d;
    logic                 err_timeout_q, err_timeout_d;
    logic                 fifo_empty;
    logic                 fifo_full;

    assign tick      = (div_q == DIV_W'(CLK_DIV - 1));
    assign fall_edge = tick && prev_level_q && !ps2c_level;

    // Free-running divider and previous-tick clock level used for edge detection.
    always_comb begin
        div_d        = tick ? '0 : div_q + 1'b1;
        prev_level_d = tick ? ps2c_level : prev_level_q;
    end

    // Input synchronisers (idle-high lines reset to 1), divider and edge history.
    always_ff @(posedge qzt_clk or posedge rst) begin
        if (rst) begin
            ps2c_meta_q  <= 1'b1;
            ps2c_sync_q  <= 1'b1;
            ps2d_meta_q  <= 1'b1;
            ps2d_sync_q  <= 1'b1;
            div_q        <= '0;
            prev_level_q <= 1'b1;
        end else begin
            ps2c_meta_q  <= PS2C;
            ps2c_sync_q  <= ps2c_meta_q;
            ps2d_meta_q  <= PS2D;
            ps2d_sync_q  <= ps2d_meta_q;
            div_q        <= div_d;
            prev_level_q <= prev_level_d;
        end
    end

`ifdef PS2_RX_GLITCH_FILTER_EN
    localparam int FLT_W = $clog2(FILTER_LEN + 1);

    logic             filt_q, filt_d;
    logic [FLT_W-1:0] flt_cnt_q, flt_cnt_d;

    assign ps2c_level = filt_q;

    // Follow the synchronised clock only after FILTER_LEN consecutive differing ticks.
    always_comb begin
        filt_d    = filt_q;
        flt_cnt_d = flt_cnt_q;
        if (tick) begin
            if (ps2c_sync_q == filt_q) begin
                flt_cnt_d = '0;
            end else if (flt_cnt_q == FLT_W'(FILTER_LEN - 1)) begin
                filt_d    = ps2c_sync_q;
                flt_cnt_d = '0;
            end else begin
                flt_cnt_d = flt_cnt_q + 1'b1;
            end
        end
    end

    // Glitch filter state.
    always_ff @(posedge qzt_clk or posedge rst) begin
        if (rst) begin
            filt_q    <= 1'b1;
            flt_cnt_q <= '0;
        end else begin
            filt_q    <= filt_d;
            flt_cnt_q <= flt_cnt_d;
        end
    end
`else
    assign ps2c_level = ps2c_sync_q;

    // FILTER_LEN has no effect here; this empty guard only keeps it referenced.
    if (FILTER_LEN < 1) begin : g_filter_len_guard
    end
`endif

    // Frame decoder next state: shifting, parity/stop checks, timeout and enable.
    always_comb begin
        state_d       = state_q;
        shift_d       = shift_q;
        bit_cnt_d     = bit_cnt_q;
        par_d         = par_q;
        to_cnt_d      = to_cnt_q;
        push_req      = 1'b0;
        err_parity_d  = 1'b0;
        err_frame_d   = 1'b0;
        err_overrun_d = 1'b0;
        err_timeout_d = 1'b0;

        if (!enable) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
            to_cnt_d  = '0;
        end else begin
            if (state_q == IDLE || fall_edge) begin
                to_cnt_d = '0;
            end else if (tick) begin
                to_cnt_d = to_cnt_q + 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (fall_edge) begin
                        if (!ps2d_sync_q) begin
                            state_d   = DATA;
                            bit_cnt_d = '0;
                        end else begin
                            err_frame_d = 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (fall_edge) begin
                        shift_d   = {ps2d_sync_q, shift_q[DATA_BITS-1:1]};
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        if (bit_cnt_q == BIT_CNT_W'(DATA_BITS - 1)) begin
                            state_d = PARITY;
                        end
                    end
                end
                PARITY: begin
                    if (fall_edge) begin
                        par_d   = ps2d_sync_q;
                        state_d = STOP;
                    end
                end
                STOP: begin
                    if (fall_edge) begin
                        state_d = IDLE;
                        if (!ps2d_sync_q) begin
                            err_frame_d = 1'b1;
                        end else if (!odd_parity_ok(shift_q, par_q)) begin
                            err_parity_d = 1'b1;
                        end else begin
                            push_req      = 1'b1;
                            err_overrun_d = fifo_full && !rd_en;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase

            if (state_q != IDLE && !fall_edge && tick &&
                to_cnt_q == TO_W'(TIMEOUT_TICKS - 1)) begin
                state_d       = IDLE;
                to_cnt_d      = '0;
                err_timeout_d = 1'b1;
            end
        end
    end

    // Frame decoder registers and registered error pulses.
    always_ff @(posedge qzt_clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            shift_q       <= '0;
            bit_cnt_q     <= '0;
            par_q         <= 1'b0;
            to_cnt_q      <= '0;
            err_parity_q  <= 1'b0;
            err_frame_q   <= 1'b0;
            err_overrun_q <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            shift_q       <= shift_d;
            bit_cnt_q     <= bit_cnt_d;
            par_q         <= par_d;
            to_cnt_q      <= to_cnt_d;
            err_parity_q  <= err_parity_d;
            err_frame_q   <= err_frame_d;
            err_overrun_q <= err_overrun_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    ps2_byte_fifo #(
        .WIDTH(DATA_BITS),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk    (qzt_clk),
        .rst    (rst),
        .wr_en  (push_req),
        .wr_data(shift_q),
        .rd_en  (rd_en),
        .rd_data(data),
        .empty  (fifo_empty),
        .full   (fifo_full)
    );

    assign valid       = !fifo_empty;
    assign full        = fifo_full;
    assign err_parity  = err_parity_q;
    assign err_frame   = err_frame_q;
    assign err_overrun = err_overrun_q;
    assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_ps2_frame_rx.sv
// Scoreboard bench for ps2_frame_rx: the stimulus side predicts the outcome of
// each frame (byte accepted or which error pulse) from the PS/2 framing rules
// and queues it; a monitor pops and compares when the DUT presents a byte or
// an error pulse.
module tb_ps2_frame_rx;

    localparam int CLK_DIV       = 4;
    localparam int TIMEOUT_TICKS = 200;
    localparam int FIFO_DEPTH    = 4;
    localparam int FILTER_LEN    = 4;
    localparam int SLOW_HALF     = 20;
    localparam int FAST_HALF     = 8;

    localparam int E_PARITY  = 1;
    localparam int E_FRAME   = 2;
    localparam int E_OVERRUN = 3;
    localparam int E_TIMEOUT = 4;

    logic       qzt_clk = 1'b0;
    logic       rst     = 1'b1;
    logic       enable  = 1'b0;
    logic       PS2C    = 1'b1;
    logic       PS2D    = 1'b1;
    logic       rd_en   = 1'b0;
    logic [7:0] data;
    logic       valid;
    logic       full;
    logic       err_parity;
    logic       err_frame;
    logic       err_overrun;
    logic       err_timeout;

    int         n_compared   = 0;
    int         n_mismatched = 0;
    logic [7:0] exp_bytes[$];
    int         exp_errs[$];
    bit         reader_on = 1'b0;

    always #5 qzt_clk = ~qzt_clk;

    ps2_frame_rx #(
        .CLK_DIV      (CLK_DIV),
        .TIMEOUT_TICKS(TIMEOUT_TICKS),
        .FIFO_DEPTH   (FIFO_DEPTH),
        .FILTER_LEN   (FILTER_LEN)
    ) dut (
        .qzt_clk    (qzt_clk),
        .rst        (rst),
        .enable     (enable),
        .PS2C       (PS2C),
        .PS2D       (PS2D),
        .rd_en      (rd_en),
        .data       (data),
        .valid      (valid),
        .full       (full),
        .err_parity (err_parity),
        .err_frame  (err_frame),
        .err_overrun(err_overrun),
        .err_timeout(err_timeout)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic checkErr(input int code, input string name);
        if (exp_errs.size() == 0) begin
            n_compared++;
            n_mismatched++;
            $display("[TB] FAIL %s: pulse=1, expected pulse=0 (none pending)", name);
        end else begin
            checkOutput(name, code, exp_errs.pop_front());
        end
    endtask

    task automatic waitTicks(input int n);
        repeat (n * CLK_DIV) @(negedge qzt_clk);
    endtask

    // Drive nbits of a frame (start, data LSB first, parity, stop) on the PS/2 lines.
    task automatic applyStimulus(input logic [7:0] b, input logic par, input logic stop,
                                 input int nbits, input int half);
        logic [10:0] bits;
        bits = {stop, par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            PS2D = bits[i];
            waitTicks(half);
            PS2C = 1'b0;
            waitTicks(half);
            PS2C = 1'b1;
        end
        PS2D = 1'b1;
        waitTicks(half);
    endtask

    // Reference model: kind 0 good frame, 1 parity error, 2 stop-bit error.
    task automatic sendFrame(input logic [7:0] b, input int kind, input int half);
        logic par;
        logic stop;
        par  = (($countones(b) % 2) == 0) ? 1'b1 : 1'b0;
        if (kind == 1) par = ~par;
        stop = (kind == 2) ? 1'b0 : 1'b1;
        if (!stop) begin
            exp_errs.push_back(E_FRAME);
        end else if ((($countones(b) + int'(par)) % 2) == 0) begin
            exp_errs.push_back(E_PARITY);
        end else if (!reader_on && exp_bytes.size() == FIFO_DEPTH) begin
            exp_errs.push_back(E_OVERRUN);
        end else begin
            exp_bytes.push_back(b);
        end
        applyStimulus(b, par, stop, 11, half);
    endtask

    task automatic waitDrain(input string name);
        int budget;
        budget = 0;
        while ((exp_bytes.size() != 0 || valid) && budget < 2000) begin
            @(negedge qzt_clk);
            budget++;
        end
        checkOutput(name, exp_bytes.size(), 0);
    endtask

    // Monitor: compare error pulses and popped bytes against the queued predictions.
    initial begin
        forever begin
            @(negedge qzt_clk);
            if (err_parity)  checkErr(E_PARITY, "err_parity");
            if (err_frame)   checkErr(E_FRAME, "err_frame");
            if (err_overrun) checkErr(E_OVERRUN, "err_overrun");
            if (err_timeout) checkErr(E_TIMEOUT, "err_timeout");
            if (reader_on && valid && $urandom_range(3) == 0) begin
                if (exp_bytes.size() == 0) begin
                    n_compared++;
                    n_mismatched++;
                    $display("[TB] FAIL fifo_byte: got 0x%0h, expected no byte", data);
                end else begin
                    checkOutput("fifo_byte", data, exp_bytes.pop_front());
                end
                rd_en = 1'b1;
            end else begin
                rd_en = reader_on && !valid && ($urandom_range(7) == 0);
            end
        end
    end

    // Watchdog so the run always ends with a summary.
    initial begin
        repeat (95000) @(posedge qzt_clk);
        n_mismatched++;
        $display("[TB] FAIL watchdog: cycles=95000, expected completion earlier");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    initial begin
        logic [7:0] rb;
        int         r;
        $display("[TB] starting ps2_frame_rx bench");

        repeat (5) @(negedge qzt_clk);
        checkOutput("reset_data", data, 8'h00);
        checkOutput("reset_valid", valid, 0);
        checkOutput("reset_full", full, 0);
        checkOutput("reset_errs", {err_parity, err_frame, err_overrun, err_timeout}, 4'h0);
        rst    = 1'b0;
        enable = 1'b1;
        waitTicks(10);

        // Single good frame at 40-tick clock period, then read it out.
        sendFrame(8'h1C, 0, SLOW_HALF);
        waitTicks(2);
        checkOutput("valid_after_1c", valid, 1);
        checkOutput("data_1c", data, 8'h1C);
        reader_on = 1'b1;
        waitDrain("drain_1c");
        waitTicks(2);
        checkOutput("valid_after_read", valid, 0);
        checkOutput("data_hold_empty", data, 8'h1C);

        // Same byte with a bad parity bit.
        sendFrame(8'h1C, 1, SLOW_HALF);
        waitTicks(4);
        checkOutput("valid_after_parity_err", valid, 0);
        checkOutput("parity_err_seen", exp_errs.size(), 0);

        // Fill the FIFO and overrun it.
        reader_on = 1'b0;
        for (int v = 1; v <= 5; v++) begin
            sendFrame(8'(v), 0, FAST_HALF);
            if (v == 3) checkOutput("full_after_3", full, 0);
            if (v == 4) checkOutput("full_after_4", full, 1);
        end
        checkOutput("full_after_5", full, 1);
        checkOutput("head_after_overrun", data, 8'h01);
        checkOutput("overrun_seen", exp_errs.size(), 0);
        reader_on = 1'b1;
        waitDrain("drain_overrun");
        checkOutput("full_after_drain", full, 0);

        // Partial frame then silence: timeout, then a good frame.
        exp_errs.push_back(E_TIMEOUT);
        applyStimulus(8'h05, 1'b0, 1'b1, 4, FAST_HALF);
        waitTicks(TIMEOUT_TICKS + 20);
        checkOutput("timeout_seen", exp_errs.size(), 0);
        sendFrame(8'hAA, 0, FAST_HALF);
        waitDrain("drain_aa");

        // Disable mid-frame: silent abort, then a good frame.
        applyStimulus(8'h33, 1'b0, 1'b1, 5, FAST_HALF);
        enable = 1'b0;
        waitTicks(5);
        enable = 1'b1;
        waitTicks(5);
        sendFrame(8'h66, 0, FAST_HALF);
        waitDrain("drain_66");
        checkOutput("enable_abort_errs", exp_errs.size(), 0);

        // Reset mid-frame, then a good frame.
        applyStimulus(8'h12, 1'b0, 1'b1, 3, FAST_HALF);
        rst = 1'b1;
        repeat (3) @(negedge qzt_clk);
        checkOutput("midreset_data", data, 8'h00);
        checkOutput("midreset_valid", valid, 0);
        checkOutput("midreset_full", full, 0);
        checkOutput("midreset_errs", {err_parity, err_frame, err_overrun, err_timeout}, 4'h0);
        rst = 1'b0;
        waitTicks(4);
        sendFrame(8'h55, 0, FAST_HALF);
        waitDrain("drain_55");
        checkOutput("data_after_55", data, 8'h55);

        // One-tick low glitch on PS2C while idle.
`ifndef PS2_RX_GLITCH_FILTER_EN
        exp_errs.push_back(E_FRAME);
`endif
        waitTicks(5);
        PS2C = 1'b0;
        repeat (CLK_DIV) @(negedge qzt_clk);
        PS2C = 1'b1;
        waitTicks(12);
        checkOutput("glitch_errs", exp_errs.size(), 0);

        // Full-length falling edge with PS2D high while idle.
        exp_errs.push_back(E_FRAME);
        PS2C = 1'b0;
        waitTicks(FAST_HALF);
        PS2C = 1'b1;
        waitTicks(FAST_HALF);
        checkOutput("idle_edge_frame_err", exp_errs.size(), 0);

        // Randomized mix of good, bad-parity and bad-stop frames.
        for (int k = 0; k < 30; k++) begin
            rb = 8'($urandom_range(255));
            r  = int'($urandom_range(99));
            sendFrame(rb, (r < 70) ? 0 : ((r < 85) ? 1 : 2), FAST_HALF);
            waitTicks(int'($urandom_range(1, 6)));
        end
        waitDrain("drain_random");
        waitTicks(4);
        checkOutput("pending_errs_end", exp_errs.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
